// File: rtl/mult8_tdm_sched.sv
// Time-multiplexed 8x8 multiplier scheduler: issues the four nibble partial
// products to one shared external 4x4 multiplier and accumulates the result.
module mult8_tdm_sched #(
   parameter int unsigned MUL_LAT   = 0,
   parameter bit          SKIP_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_a,
   input  logic [7:0]  in_b,
   output logic [3:0]  mul_a,
   output logic [3:0]  mul_b,
   input  logic [7:0]  mul_p,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_p,
   output logic        out_ovf,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      r_state, w_next;
   logic [7:0]  r_a, r_b;
   logic [16:0] r_acc;
   logic [2:0]  r_idx;
   logic [15:0] r_out_p;
   logic        r_out_ovf;

   logic [3:0]  w_na [4];
   logic [3:0]  w_nb [4];
   logic [3:0]  w_cand;
   logic        w_issue;
   logic [1:0]  w_sel;
   logic [1:0]  w_sh;
   logic        w_ret_v;
   logic [1:0]  w_ret_sh;
   logic        w_pend;
   logic        w_cap;
   logic        w_fin;
   logic [16:0] w_acc_nxt;

   // PP index bit0 selects the A nibble, bit1 the B nibble
   always_comb begin
      w_na[0] = r_a[3:0];  w_nb[0] = r_b[3:0];
      w_na[1] = r_a[7:4];  w_nb[1] = r_b[3:0];
      w_na[2] = r_a[3:0];  w_nb[2] = r_b[7:4];
      w_na[3] = r_a[7:4];  w_nb[3] = r_b[7:4];
   end

   // Lowest pending non-skipped PP is issued; skipped ones cost no cycle
   always_comb begin
      w_cand  = '0;
      w_issue = 1'b0;
      w_sel   = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         w_cand[i] = (r_state == S_RUN) && (3'(i) >= r_idx) &&
                     (!SKIP_ZERO || ((w_na[i] != 4'd0) && (w_nb[i] != 4'd0)));
      end
      for (int unsigned i = 0; i < 4; i++) begin
         if (!w_issue && w_cand[i]) begin
            w_issue = 1'b1;
            w_sel   = 2'(i);
         end
      end
   end

   assign w_sh = (w_sel == 2'd0) ? 2'd0 : ((w_sel == 2'd3) ? 2'd2 : 2'd1);

   generate
      if (MUL_LAT == 0) begin : g_comb
         assign w_ret_v  = w_issue;
         assign w_ret_sh = w_sh;
         assign w_pend   = 1'b0;
      end else begin : g_pipe
         logic [MUL_LAT-1:0] r_pv;
         logic [1:0]         r_psh [MUL_LAT];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_pv <= '0;
               for (int unsigned k = 0; k < MUL_LAT; k++) r_psh[k] <= '0;
            end else begin
               r_pv[0]  <= w_issue;
               r_psh[0] <= w_sh;
               for (int unsigned k = 1; k < MUL_LAT; k++) begin
                  r_pv[k]  <= r_pv[k-1];
                  r_psh[k] <= r_psh[k-1];
               end
            end
         end

         assign w_ret_v  = r_pv[MUL_LAT-1];
         assign w_ret_sh = r_psh[MUL_LAT-1];
         assign w_pend   = |r_pv;
      end
   endgenerate

   assign w_cap     = in_valid && (r_state == S_IDLE);
   assign w_fin     = (r_state == S_RUN) && !w_issue && !w_pend;
   assign w_acc_nxt = r_acc + (w_ret_v ? ({9'd0, mul_p} << {w_ret_sh, 2'b00}) : 17'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      mul_a     = '0;
      mul_b     = '0;
      unique case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) w_next = S_RUN;
         end
         S_RUN: begin
            if (w_issue) begin
               mul_a = w_na[w_sel];
               mul_b = w_nb[w_sel];
            end
            if (w_fin) w_next = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a       <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_idx     <= '0;
         r_out_p   <= '0;
         r_out_ovf <= 1'b0;
      end else if (w_cap) begin
         r_a   <= in_a;
         r_b   <= in_b;
         r_acc <= '0;
         r_idx <= '0;
      end else if (r_state == S_RUN) begin
         r_acc <= w_acc_nxt;
         r_idx <= w_issue ? ({1'b0, w_sel} + 3'd1) : 3'd4;
         // No return is in flight when w_fin is high, so r_acc is final
         if (w_fin) begin
            r_out_p   <= r_acc[15:0];
            r_out_ovf <= r_acc[16];
         end
      end
   end

   assign out_p   = r_out_p;
   assign out_ovf = r_out_ovf;

endmodule

// File: tb/tb_mult8_tdm_sched.sv
// Directed bench for mult8_tdm_sched: four instances cover the latency and
// skip configurations, each fed by an exact (or saturating) 4x4 model.
module tb_mult8_tdm_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_a = '0, in_b = '0;
   logic        out_ready = 1'b0;
   logic [3:0]  iv = '0;
   logic [3:0]  ir, ov, ovf, bsy;
   logic [3:0]  ma [4];
   logic [3:0]  mb [4];
   logic [7:0]  mp [4];
   logic [15:0] op [4];
   logic [7:0]  prod [4];
   logic [7:0]  d1 [4];
   logic [7:0]  d2 [4];
   logic [7:0]  d3 [4];
   logic        approx0 = 1'b0;
   logic [7:0]  seq [16];
   int          n_cmp = 0, n_bad = 0;
   int          cyc;

   always #5 clk = ~clk;

   // inst 0: LAT0/no-skip, 1: LAT2/skip, 2: LAT0/skip, 3: LAT3/skip
   for (genvar g = 0; g < 4; g++) begin : g_dut
      mult8_tdm_sched #(
         .MUL_LAT  ((g == 1) ? 2 : ((g == 3) ? 3 : 0)),
         .SKIP_ZERO(g != 0)
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (iv[g]),
         .in_ready (ir[g]),
         .in_a     (in_a),
         .in_b     (in_b),
         .mul_a    (ma[g]),
         .mul_b    (mb[g]),
         .mul_p    (mp[g]),
         .out_valid(ov[g]),
         .out_ready(out_ready),
         .out_p    (op[g]),
         .out_ovf  (ovf[g]),
         .busy     (bsy[g])
      );
   end

   always_comb begin
      for (int k = 0; k < 4; k++) prod[k] = 8'(ma[k]) * 8'(mb[k]);
      mp[0] = approx0 ? 8'hFF : prod[0];
      mp[1] = d2[1];
      mp[2] = prod[2];
      mp[3] = d3[3];
   end

   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         d1[k] <= prod[k];
         d2[k] <= d1[k];
         d3[k] <= d2[k];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start(input int k, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      in_a  = a;
      in_b  = b;
      iv[k] = 1'b1;
      check("ready_before_capture", 32'(ir[k]), 32'd1);
      @(posedge clk);
      #1 iv[k] = 1'b0;
   endtask

   // cycles from capture edge to out_valid; seq[i] = {mul_a,mul_b} in cycle i+1
   task automatic wait_done(input int k);
      for (int i = 0; i < 16; i++) seq[i] = '0;
      cyc = 0;
      while (!ov[k] && cyc < 40) begin
         if (cyc < 16) seq[cyc] = {ma[k], mb[k]};
         @(posedge clk);
         #1 cyc++;
      end
   endtask

   task automatic release_op(input int k);
      @(negedge clk);
      iv[k]     = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("released_valid", 32'(ov[k]), 32'd0);
      check("released_ready", 32'(ir[k]), 32'd1);
      check("released_busy",  32'(bsy[k]), 32'd0);
   endtask

   initial begin
      #1;
      check("rst_ready", 32'(ir[0]),  32'd1);
      check("rst_valid", 32'(ov[0]),  32'd0);
      check("rst_busy",  32'(bsy[0]), 32'd0);
      check("rst_p",     32'(op[0]),  32'd0);
      check("rst_ovf",   32'(ovf[0]), 32'd0);
      check("rst_mul",   32'({ma[0], mb[0]}), 32'd0);
      #13 rst_n = 1'b1;

      // FF*FF, all four PPs issued, combinational multiplier
      start(0, 8'hFF, 8'hFF);
      check("run_busy", 32'(bsy[0]), 32'd1);
      wait_done(0);
      check("ff_latency", 32'(cyc), 32'd5);
      check("ff_p",   32'(op[0]),  32'hFE01);
      check("ff_ovf", 32'(ovf[0]), 32'd0);
      for (int i = 0; i < 4; i++) check("ff_issue", 32'(seq[i]), 32'hFF);
      check("ff_idle_mul", 32'(seq[4]), 32'h00);
      release_op(0);

      // 0x12*0x34, latency 2
      start(1, 8'h12, 8'h34);
      wait_done(1);
      check("lat2_latency", 32'(cyc), 32'd7);
      check("lat2_p",  32'(op[1]), 32'h03A8);
      check("lat2_s0", 32'(seq[0]), 32'h24);
      check("lat2_s1", 32'(seq[1]), 32'h14);
      check("lat2_s2", 32'(seq[2]), 32'h23);
      check("lat2_s3", 32'(seq[3]), 32'h13);
      release_op(1);

      // all PPs skipped
      start(2, 8'h00, 8'h5A);
      wait_done(2);
      check("zero_latency", 32'(cyc), 32'd1);
      check("zero_p",   32'(op[2]), 32'h0000);
      check("zero_mul", 32'(seq[0]), 32'h00);
      release_op(2);

      // only PP2 survives
      start(2, 8'h0F, 8'hF0);
      wait_done(2);
      check("pp2_latency", 32'(cyc), 32'd2);
      check("pp2_p",  32'(op[2]), 32'h0E10);
      check("pp2_s0", 32'(seq[0]), 32'hFF);
      check("pp2_s1", 32'(seq[1]), 32'h00);
      release_op(2);

      // saturating sub-multiplier: 255 + 2*255*16 + 255*256 = 73695
      approx0 = 1'b1;
      start(0, 8'h11, 8'h22);
      wait_done(0);
      check("ovs_latency", 32'(cyc), 32'd5);
      check("ovs_p",   32'(op[0]),  32'h1FDF);
      check("ovs_ovf", 32'(ovf[0]), 32'd1);

      // back-pressure in DONE with in_valid toggling
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         iv[0] = ~iv[0];
         in_a  = 8'(i);
         @(posedge clk);
         #1;
         check("hold_p",     32'(op[0]), 32'h1FDF);
         check("hold_ready", 32'(ir[0]), 32'd0);
         check("hold_valid", 32'(ov[0]), 32'd1);
      end
      release_op(0);
      approx0 = 1'b0;
      @(posedge clk);
      #1 check("no_capture_busy", 32'(bsy[0]), 32'd0);

      // async reset during second RUN cycle, latency 3
      start(3, 8'hAB, 8'hCD);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_ready", 32'(ir[3]),  32'd1);
      check("abort_valid", 32'(ov[3]),  32'd0);
      check("abort_busy",  32'(bsy[3]), 32'd0);
      check("abort_mul",   32'({ma[3], mb[3]}), 32'd0);
      check("abort_p",     32'(op[3]),  32'd0);
      check("abort_ovf",   32'(ovf[3]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      start(3, 8'h03, 8'h05);
      wait_done(3);
      check("post_latency", 32'(cyc), 32'd5);
      check("post_p",   32'(op[3]),  32'h000F);
      check("post_ovf", 32'(ovf[3]), 32'd0);
      release_op(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
